// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
// FSM states, Booth digit codes and the extended-width helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Magnitude of a Booth digit; the sign travels separately.
    typedef enum logic [1:0] {
        DIG_ZERO = 2'd0,
        DIG_PM1  = 2'd1,
        DIG_PM2  = 2'd2
    } digit_e;

    localparam logic DIG_NEG = 1'b1;

    // Operands are widened to an even width with at least one guard bit,
    // so unsigned all-ones values are never misread as negative.
    function automatic int ext_width(input int w);
        return (w % 2 == 0) ? w + 2 : w + 1;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder.
// Maps the {Q[1],Q[0],Q(-1)} window to a signed multiple select.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic       neg,
    output logic       one,
    output logic       two
);

    digit_e digit;

    // Recode the window into a digit magnitude and a negate flag.
    always_comb begin
        digit = DIG_ZERO;
        neg   = 1'b0;
        case (window)
            3'b001,
            3'b010: digit = DIG_PM1;
            3'b011: digit = DIG_PM2;
            3'b100: begin
                digit = DIG_PM2;
                neg   = DIG_NEG;
            end
            3'b101,
            3'b110: begin
                digit = DIG_PM1;
                neg   = DIG_NEG;
            end
            default: begin
                digit = DIG_ZERO;
                neg   = 1'b0;
            end
        endcase
        one = (digit == DIG_PM1);
        two = (digit == DIG_PM2);
    end

endmodule

// File: rtl/booth_multiplier_r4.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle.
// Signed or unsigned per operation, valid/ready on both sides.
module booth_multiplier_r4
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int EW   = ext_width(WIDTH);
    localparam int ITER = EW / 2;
    localparam int AW   = EW + 2;
    localparam int CW   = $clog2(ITER + 1);

    state_e state;
    state_e state_next;

    logic [AW-1:0] acc;
    logic [EW-1:0] m_reg;
    logic [EW-1:0] q_reg;
    logic          q_m1;
    logic [CW-1:0] cnt;

    logic          neg;
    logic          one;
    logic          two;
    logic          last_step;
    logic          ext_m;
    logic          ext_q;

    logic [AW-1:0] m_ext;
    logic [AW-1:0] mult;
    logic [AW-1:0] addend;
    logic [AW-1:0] acc_sum;

    logic signed [AW+EW:0] joined;
    logic [AW+EW:0]        shifted;

    booth_r4_encoder u_enc (
        .window ({q_reg[1:0], q_m1}),
        .neg    (neg),
        .one    (one),
        .two    (two)
    );

    assign last_step = (cnt == CW'(ITER - 1));
    assign ext_m     = signed_mode & M[WIDTH-1];
    assign ext_q     = signed_mode & Q[WIDTH-1];

    assign m_ext   = {{2{m_reg[EW-1]}}, m_reg};
    assign mult    = two ? {m_ext[AW-2:0], 1'b0} :
                     one ? m_ext : '0;
    assign addend  = neg ? (~mult + AW'(1)) : mult;
    assign acc_sum = acc + addend;
    assign joined  = {acc_sum, q_reg, q_m1};
    assign shifted = joined >>> 2;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand load, Booth step with shift, and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            m_reg  <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (state == IDLE && in_valid) begin
            m_reg <= {{(EW-WIDTH){ext_m}}, M};
            q_reg <= {{(EW-WIDTH){ext_q}}, Q};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (state == CALC) begin
            acc   <= shifted[AW+EW:EW+1];
            q_reg <= shifted[EW:1];
            q_m1  <= shifted[0];
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                result <= shifted[2*WIDTH:1];
            end
        end
    end

endmodule
